gen_cla_serial_adder: RTL and testbench

//  Multi-cycle, chunk-serial successor to the decomposed CLA adder. Adds or subtracts
//  two NBIT operands by running one CBIT-wide decomposed CLA chunk per cycle through a

---
 rtl/gen_cla_serial_adder_pkg.sv | 16 +
 rtl/gen_cla_serial_adder_cla_chunk.sv | 49 ++++
 rtl/gen_cla_serial_adder.sv | 136 +++++++++++++
 tb/tb_gen_cla_serial_adder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/gen_cla_serial_adder_pkg.sv
// Shared sizing constants and FSM encoding for the chunk-serial CLA adder.
package gen_cla_serial_adder_pkg;

    localparam int unsigned NBIT   = 16;
    localparam int unsigned CBIT   = 4;
    localparam int unsigned NCHUNK = NBIT / CBIT;
    localparam int unsigned CNTW   = $clog2(NCHUNK + 1);
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gen_cla_serial_adder_cla_chunk.sv
// Combinational W-bit decomposed carry-lookahead adder chunk.
module cla_chunk
    import gen_cla_serial_adder_pkg::*;
#(
    parameter int unsigned W = CBIT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_msb_in,
    output logic         c_out
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   cy;
    logic         term;

    assign g = a & b;
    assign p = a ^ b;

    // Nonlinear part: every carry expanded as a flat sum of generate/propagate products.
    always_comb begin
        cy    = '0;
        term  = 1'b0;
        cy[0] = c_in;
        for (int i = 0; i < int'(W); i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                cy[i+1] = cy[i+1] | term;
            end
            term = c_in;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            cy[i+1] = cy[i+1] | term;
        end
    end

    // Linear part: sum is propagate xor incoming carry.
    assign s        = p ^ cy[W-1:0];
    assign c_msb_in = cy[W-1];
    assign c_out    = cy[W];

endmodule

// File: rtl/gen_cla_serial_adder.sv
// Multi-cycle adder/subtractor that runs one CLA chunk per cycle through a carry register.
module gen_cla_serial_adder
    import gen_cla_serial_adder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            c_out,
    output logic            ovf
);

    if ((CBIT < 1) || ((NBIT % CBIT) != 0)) begin : g_bad_params
        $error("gen_cla_serial_adder: NBIT must be a nonzero multiple of CBIT");
    end

    typedef logic [NCHUNK-1:0][CBIT-1:0] word_t;

    state_t          state_q, state_n;
    logic [CNTW-1:0] cnt_q, cnt_n;
    word_t           a_q, a_n;
    word_t           b_q, b_n;
    word_t           s_q, s_n;
    logic            carry_q, carry_n;
    logic            c_out_q, c_out_n;
    logic            ovf_q, ovf_n;
    logic            in_ready_q, in_ready_n;
    logic            out_valid_q, out_valid_n;

    logic [IDXW-1:0] idx;
    logic [CBIT-1:0] chunk_s;
    logic            chunk_c_msb_in;
    logic            chunk_c_out;

    assign idx = IDXW'(cnt_q);

    cla_chunk #(.W(CBIT)) u_chunk (
        .a        (a_q[idx]),
        .b        (b_q[idx]),
        .c_in     (carry_q),
        .s        (chunk_s),
        .c_msb_in (chunk_c_msb_in),
        .c_out    (chunk_c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            a_q         <= a_n;
            b_q         <= b_n;
            s_q         <= s_n;
            carry_q     <= carry_n;
            c_out_q     <= c_out_n;
            ovf_q       <= ovf_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        a_n         = a_q;
        b_n         = b_q;
        s_n         = s_q;
        carry_n     = carry_q;
        c_out_n     = c_out_q;
        ovf_n       = ovf_q;
        in_ready_n  = in_ready_q;
        out_valid_n = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtraction is a + ~b + 1, so c_in is replaced by the forced one.
                    a_n        = a;
                    b_n        = b ^ {NBIT{sub}};
                    carry_n    = sub ? 1'b1 : c_in;
                    s_n        = '0;
                    cnt_n      = '0;
                    in_ready_n = 1'b0;
                    state_n    = RUN;
                end
            end
            RUN: begin
                s_n[idx] = chunk_s;
                carry_n  = chunk_c_out;
                if (cnt_q == CNTW'(NCHUNK - 1)) begin
                    c_out_n     = chunk_c_out;
                    ovf_n       = chunk_c_msb_in ^ chunk_c_out;
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    cnt_n = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_gen_cla_serial_adder.sv
// Self-checking bench for gen_cla_serial_adder against an integer-arithmetic model.
module tb_gen_cla_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;
    time last_accept;

    always #5 clk = ~clk;

    gen_cla_serial_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, c_out, s} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic sb);
        int xu, yu, xs, ys, usum, ssum;
        logic [15:0] r;
        logic co, ov;
        xu = int'(x);
        yu = int'(y);
        xs = int'($signed(x));
        ys = int'($signed(y));
        if (sb) begin
            usum = xu - yu;
            co   = (xu >= yu);
            ssum = xs - ys;
        end else begin
            usum = xu + yu + int'(ci);
            co   = (usum > 65535);
            ssum = xs + ys + int'(ci);
        end
        r  = 16'(usum);
        ov = (ssum > 32767) || (ssum < -32768);
        return {ov, co, r};
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_s"}, 32'(s), 32'd0);
        check({tag, "_c_out"}, 32'(c_out), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // Full transaction; called at posedge+1 with the block expected idle.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tci, input logic tsub, input int hold,
                          input bit chk_tput);
        logic [17:0] e;
        int lat;
        e = ref_op(ta, tb, tci, tsub);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta; b = tb; c_in = tci; sub = tsub;
        @(posedge clk);
        if (chk_tput) check({tag, "_tput"}, 32'($time - last_accept), 32'd60);
        last_accept = $time;
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_s"}, 32'(s), 32'(e[15:0]));
        check({tag, "_c_out"}, 32'(c_out), 32'(e[16]));
        check({tag, "_ovf"}, 32'(ovf), 32'(e[17]));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_s"}, 32'(s), 32'(e[15:0]));
            check({tag, "_hold_c_out"}, 32'(c_out), 32'(e[16]));
            check({tag, "_hold_ovf"}, 32'(ovf), 32'(e[17]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_hs_in_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        last_accept = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_reset("reset");

        run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op("wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
        run_op("sub_neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_op("cin_add",     16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b0);
        run_op("hold",        16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 3, 1'b0);

        // Abort mid-RUN: two chunk cycles, then reset.
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_reset("abort");
        run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   0, i > 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
